mipi_bank_arb: RTL

Round-robin arbiter and sequencer that shares the single MIPI master inside the packet decoder among up to four MIPI banks (SCLK/SDA pairs). Each bank requester raises a level request. The arbiter selects one, switches the bank mux, lets the lines settle, starts one master frame, waits for completion, then releases. It sits between the per-bank command sources and the `mipi_bank` select and start/done handshake of the shared master, on the `mclk` domain.

---
 rtl/mipi_bank_arb.sv | 83 ++++++++
 1 files changed

// File: rtl/mipi_bank_arb.sv
// mipi_bank_arb: round-robin arbiter sharing one MIPI master among NREQ banks.
// Define MIPI_ARB_TIMEOUT_EN to enable the WAIT watchdog and sticky timeout_err.
module mipi_bank_arb #(
  parameter int          NREQ        = 4,
  parameter int          BANK_NBIT   = 2,
  parameter int          SETTLE_CYC  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [BANK_NBIT-1:0] mipi_bank,
  output logic                 mipi_start,
  input  logic                 mipi_done,
  output logic                 arb_busy,
  output logic                 timeout_err,
  input  logic                 err_clr
);
  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, RELEASE} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt;
  logic [BANK_NBIT-1:0] ptr, win;
  logic to;
  // Scan downward in priority so the closest set bit at/after ptr wins last.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      for (int j = 0; j < NREQ; j++)
        if (req[j] && j == (int'(ptr) + i) % NREQ) win = BANK_NBIT'(j);
  end
`ifdef MIPI_ARB_TIMEOUT_EN
  logic [15:0] wd;
  assign to = state == WAIT && !mipi_done && wd == TIMEOUT_CYC - 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd          <= state == START ? '0 : state == WAIT ? wd + 16'd1 : wd;
      timeout_err <= to | (timeout_err & ~err_clr);
    end
`else
  logic unused_cfg;
  assign to          = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = ^{err_clr, TIMEOUT_CYC};
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = |req ? SETTLE : IDLE;
      SETTLE:  state_nxt = cnt == 8'd0 ? START : SETTLE;
      START:   state_nxt = WAIT;
      WAIT:    state_nxt = (mipi_done || to) ? RELEASE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      grant     <= '0;
      mipi_bank <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req) begin
        grant     <= NREQ'(1) << win;
        mipi_bank <= win;
        cnt       <= 8'(SETTLE_CYC);
      end
      if (state == SETTLE) cnt <= cnt - 8'd1;
      if (state == RELEASE) begin
        grant <= '0;
        ptr   <= int'(mipi_bank) == NREQ - 1 ? '0 : mipi_bank + 1'b1;
      end
    end
  assign mipi_start = state == START;
  assign arb_busy   = state != IDLE;
  assign done       = state == RELEASE ? grant : '0;
endmodule
